pixel_pack_fifo: RTL

Stream-to-word packer that sits directly downstream of the crop stage in the DVP video path. It takes the cropped, gappy pixel stream (vs/de/24-bit RGB) and converts each pixel to RGB565. It packs two pixels per 32-bit word and buffers the words in a small first-word-fall-through FIFO, which feeds the frame-buffer DMA writer through a valid/ready handshake with a start-of-frame tag.

---
 rtl/pixel_pack_fifo.sv | 119 +++++++++++
 1 files changed

// File: rtl/pixel_pack_fifo.sv
// Converts cropped 24-bit RGB pixels to RGB565, packs two per 32-bit word with a
// start-of-frame tag, and buffers the words in a first-word-fall-through FIFO.
module pixel_pack_fifo #(
    parameter int unsigned FIFO_AW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vs_i,
    input  logic                 de_i,
    input  logic [23:0]          rgb_i,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [31:0]          m_data,
    output logic                 m_sof,
    output logic [FIFO_AW:0]     fill,
    output logic                 overflow,
    output logic [15:0]          last_frame_words
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned FW    = FIFO_AW + 1;

    typedef struct packed {
        logic        sof;
        logic [31:0] data;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               vs_d;
    logic               half_valid;
    logic [15:0]        lo;
    logic               sof_pending;
    logic [15:0]        frame_cnt;

    logic [15:0] p565;
    logic        fs;
    logic        pix_en;
    logic        push_req;
    logic        push_ok;
    logic        pop;
    logic        full;
    logic        unused_rgb;
    entry_t      head;

    assign p565       = {rgb_i[23:19], rgb_i[15:10], rgb_i[7:3]};
    assign unused_rgb = ^{rgb_i[18:16], rgb_i[9:8], rgb_i[2:0]};
    assign fs         = vs_i & ~vs_d;
    assign pix_en     = de_i & ~vs_i;
    assign push_req   = pix_en & half_valid;
    assign full       = (fill == FW'(DEPTH));
    assign pop        = m_valid & m_ready;
    assign push_ok    = push_req & (~full | pop);

    // Head entry falls through straight from storage; gated so idle outputs read zero.
    assign head    = mem[rd_ptr];
    assign m_valid = (fill != '0);
    assign m_data  = m_valid ? head.data : 32'h0;
    assign m_sof   = m_valid & head.sof;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= '{sof: sof_pending, data: {p565, lo}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push_ok, pop})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Packer, frame tagging and per-frame statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d             <= 1'b0;
            half_valid       <= 1'b0;
            lo               <= 16'h0;
            sof_pending      <= 1'b0;
            overflow         <= 1'b0;
            frame_cnt        <= 16'h0;
            last_frame_words <= 16'h0;
        end else begin
            vs_d <= vs_i;
            if (fs) begin
                half_valid       <= 1'b0;
                sof_pending      <= 1'b1;
                overflow         <= 1'b0;
                last_frame_words <= frame_cnt;
                frame_cnt        <= 16'h0;
            end else if (pix_en) begin
                if (!half_valid) begin
                    lo         <= p565;
                    half_valid <= 1'b1;
                end else begin
                    half_valid <= 1'b0;
                    if (push_ok) begin
                        sof_pending <= 1'b0;
                        if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
